// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - issue-side sequencer for the funct-coded ALU/shifter/multiplier datapath (optional macro ALU_SEQ_BACK2BACK_EN)
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 32,
    parameter int SETTLE     = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_req_funct,
    input  logic [31:0] i_req_a,
    input  logic [31:0] i_req_b,
    output logic [5:0]  o_alu_signal,
    output logic [31:0] o_alu_dataA,
    output logic [31:0] o_alu_dataB,
    input  logic [31:0] i_alu_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_lo,
    output logic [31:0] o_rsp_hi,
    output logic        o_rsp_err
);

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_NOP   = 6'b000000;

    localparam int CNT_MAX = (MUL_CYCLES > SETTLE) ? MUL_CYCLES : SETTLE;
    localparam int CW      = $clog2(CNT_MAX + 1);

    // Counters are loaded with (length - 1) on state entry and the state exits on zero.
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE - 1);
    localparam logic [CW-1:0] MUL_LD    = CW'(MUL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_MUL_RUN,
        S_RD_HI,
        S_RD_LO,
        S_RESP
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    state_t          w_launch_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [CW-1:0]   w_launch_cnt;
    logic [5:0]      r_funct;
    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_rsp_lo;
    logic [31:0]     r_rsp_hi;
    logic            r_rsp_err;
    logic            w_accept;
    logic            w_is_logic;
    logic            w_is_mul;
    logic            w_sample_lo;
    logic            w_sample_hi;
    logic            w_clr_hi;
    logic [5:0]      w_alu_signal;

    // Classify the incoming funct code and pick the state/count an accepted request starts in.
    always_comb begin
        w_is_mul   = (i_req_funct == F_MULTU);
        w_is_logic = (i_req_funct == F_AND) || (i_req_funct == F_OR)  ||
                     (i_req_funct == F_ADD) || (i_req_funct == F_SUB) ||
                     (i_req_funct == F_SLT) || (i_req_funct == F_SLL);
        if (w_is_mul) begin
            w_launch_state = S_MUL_RUN;
            w_launch_cnt   = MUL_LD;
        end else if (w_is_logic) begin
            w_launch_state = S_ISSUE;
            w_launch_cnt   = SETTLE_LD;
        end else begin
            w_launch_state = S_RESP;
            w_launch_cnt   = '0;
        end
    end

    // Request acceptance: normally only when idle; back-to-back mode also accepts while a response retires.
    always_comb begin
`ifdef ALU_SEQ_BACK2BACK_EN
        o_req_ready = (r_state == S_IDLE) || ((r_state == S_RESP) && i_rsp_ready);
`else
        o_req_ready = (r_state == S_IDLE);
`endif
        w_accept = i_req_valid && o_req_ready;
    end

    // State and dwell-counter register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, dwell counting, datapath funct code and result-sample strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sample_lo  = 1'b0;
        w_sample_hi  = 1'b0;
        w_clr_hi     = 1'b0;
        w_alu_signal = F_NOP;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_launch_state;
                    w_cnt_nxt   = w_launch_cnt;
                end
            end
            S_ISSUE: begin
                w_alu_signal = r_funct;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    w_sample_lo = 1'b1;
                    w_clr_hi    = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_MUL_RUN: begin
                w_alu_signal = F_MULTU;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RD_HI;
                    w_cnt_nxt   = SETTLE_LD;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RD_HI: begin
                w_alu_signal = F_MFHI;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RD_LO;
                    w_cnt_nxt   = SETTLE_LD;
                    w_sample_hi = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RD_LO: begin
                w_alu_signal = F_MFLO;
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                    w_sample_lo = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    if (w_accept) begin
                        w_state_nxt = w_launch_state;
                        w_cnt_nxt   = w_launch_cnt;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Request capture and response registers; an invalid funct leaves the operand registers untouched.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_funct   <= F_NOP;
            r_a       <= '0;
            r_b       <= '0;
            r_rsp_lo  <= '0;
            r_rsp_hi  <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_funct <= i_req_funct;
                if (w_is_logic || w_is_mul) begin
                    r_a       <= i_req_a;
                    r_b       <= i_req_b;
                    r_rsp_err <= 1'b0;
                end else begin
                    r_rsp_err <= 1'b1;
                    r_rsp_lo  <= '0;
                    r_rsp_hi  <= '0;
                end
            end
            if (w_sample_lo) begin
                r_rsp_lo <= i_alu_result;
            end
            if (w_sample_hi) begin
                r_rsp_hi <= i_alu_result;
            end else if (w_clr_hi) begin
                r_rsp_hi <= '0;
            end
        end
    end

    assign o_alu_signal = w_alu_signal;
    assign o_alu_dataA  = r_a;
    assign o_alu_dataB  = r_b;
    assign o_rsp_valid  = (r_state == S_RESP);
    assign o_rsp_lo     = r_rsp_lo;
    assign o_rsp_hi     = r_rsp_hi;
    assign o_rsp_err    = r_rsp_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - directed self-checking bench for alu_op_sequencer
module tb_alu_op_sequencer;

    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000010;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_BAD   = 6'b111000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_funct;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [5:0]  alu_signal;
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [31:0] alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.MUL_CYCLES(32), .SETTLE(2)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_funct  (req_funct),
        .i_req_a      (req_a),
        .i_req_b      (req_b),
        .o_alu_signal (alu_signal),
        .o_alu_dataA  (alu_dataA),
        .o_alu_dataB  (alu_dataB),
        .i_alu_result (alu_result),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_lo     (rsp_lo),
        .o_rsp_hi     (rsp_hi),
        .o_rsp_err    (rsp_err)
    );

    // Datapath stand-in: HiLo captures the product while MULTU is driven.
    always @(posedge clk) begin
        if (alu_signal == F_MULTU) begin
            {m_hi, m_lo} <= {32'b0, alu_dataA} * {32'b0, alu_dataB};
        end
    end

    always_comb begin
        alu_result = '0;
        case (alu_signal)
            F_AND:   alu_result = alu_dataA & alu_dataB;
            F_OR:    alu_result = alu_dataA | alu_dataB;
            F_ADD:   alu_result = alu_dataA + alu_dataB;
            F_SUB:   alu_result = alu_dataA - alu_dataB;
            F_SLT:   alu_result = {31'b0, ($signed(alu_dataA) < $signed(alu_dataB))};
            F_SLL:   alu_result = alu_dataA << alu_dataB[4:0];
            F_MFHI:  alu_result = m_hi;
            F_MFLO:  alu_result = m_lo;
            default: alu_result = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input int exp_iss,
                          input int exp_rd, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input logic exp_err, input int hold);
        int lat, n_iss, n_rhi, n_rlo;
        lat = 0; n_iss = 0; n_rhi = 0; n_rlo = 0;
        @(negedge clk);
        rsp_ready = (hold == 0);
        req_funct = f; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (alu_signal == F_MFHI) n_rhi++;
            else if (alu_signal == F_MFLO) n_rlo++;
            else if (alu_signal != 6'b0 && alu_signal == f) n_iss++;
            if (rsp_valid) break;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, " issue_cycles"}, 64'(n_iss), 64'(exp_iss));
        chk({tag, " mfhi_cycles"}, 64'(n_rhi), 64'(exp_rd));
        chk({tag, " mflo_cycles"}, 64'(n_rlo), 64'(exp_rd));
        chk({tag, " rsp_lo"}, 64'(rsp_lo), 64'(exp_lo));
        chk({tag, " rsp_hi"}, 64'(rsp_hi), 64'(exp_hi));
        chk({tag, " rsp_err"}, 64'(rsp_err), 64'(exp_err));
        chk({tag, " resp_alu_signal"}, 64'(alu_signal), 64'(0));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold_valid"}, 64'(rsp_valid), 64'(1));
            chk({tag, " hold_lo"}, 64'(rsp_lo), 64'(exp_lo));
            chk({tag, " hold_req_ready"}, 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " post_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, " post_req_ready"}, 64'(req_ready), 64'(1));
    endtask

    initial begin
        int seen;
        rst_n = 1'b1; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst req_ready", 64'(req_ready), 64'(1));
        chk("rst rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst rsp_err", 64'(rsp_err), 64'(0));
        chk("rst rsp_lo_hi", {rsp_hi, rsp_lo}, 64'(0));
        chk("rst alu_signal", 64'(alu_signal), 64'(0));
        chk("rst operands", {alu_dataA, alu_dataB}, 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("add",   F_ADD,   32'd5,        32'd7,        3,  2,  0, 32'd12,         32'd0, 1'b0, 0);
        run_op("sub",   F_SUB,   32'd3,        32'd5,        3,  2,  0, 32'hFFFF_FFFE,  32'd0, 1'b0, 0);
        run_op("slt",   F_SLT,   32'd3,        32'd5,        3,  2,  0, 32'd1,          32'd0, 1'b0, 0);
        run_op("and",   F_AND,   32'hFF00_FF00, 32'h0FF0_0FF0, 3, 2, 0, 32'h0F00_0F00,  32'd0, 1'b0, 0);
        run_op("sll",   F_SLL,   32'd1,        32'd31,       3,  2,  0, 32'h8000_0000,  32'd0, 1'b0, 0);
        run_op("multu", F_MULTU, 32'hFFFF_FFFF, 32'd2,       37, 32, 2, 32'hFFFF_FFFE,  32'd1, 1'b0, 0);
        run_op("bad",   F_BAD,   32'd9,        32'd9,        1,  0,  0, 32'd0,          32'd0, 1'b1, 0);
        chk("bad operands_untouched", {alu_dataA, alu_dataB}, {32'hFFFF_FFFF, 32'd2});
        run_op("or_hold", F_OR,  32'hF0,       32'h0F,       3,  2,  0, 32'hFF,         32'd0, 1'b0, 10);

        @(negedge clk);
        req_funct = F_MULTU; req_a = 32'hFFFF_FFFF; req_b = 32'd2; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort running", 64'(alu_signal), 64'(F_MULTU));
        rst_n = 1'b0;
        #1;
        chk("abort alu_signal", 64'(alu_signal), 64'(0));
        chk("abort operands", {alu_dataA, alu_dataB}, 64'(0));
        chk("abort req_ready", 64'(req_ready), 64'(1));
        chk("abort rsp_valid", 64'(rsp_valid), 64'(0));
        chk("abort rsp_lo_hi", {rsp_hi, rsp_lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("abort no_response", 64'(seen), 64'(0));
        run_op("add_after", F_ADD, 32'd1, 32'd1, 3, 2, 0, 32'd2, 32'd0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
